// File: rtl/apb_event_slave.sv
// -----------------------------------------------------------------------------
// apb_event_slave
//
// APB completer at the slave end of the event bus. Writes to one of three
// event registers bump that event's saturating counter and capture the write
// data into LAST. Counters, LAST and the CFG register are readable over the
// same port. CFG[3:0] inserts a programmable number of wait states before
// PREADY so the initiator's wait handling gets exercised.
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 CNT_A   R: count (zero-extended)   W: count+1 (saturating), LAST <= data
//   0x04 CNT_B   as CNT_A
//   0x08 CNT_C   as CNT_A
//   0x0C LAST    R: last event data         W: error
//   0x10 CFG     R/W [3:0] WAIT; a write with bit 31 set also clears CNT_A/B/C
//   Offset above 0x10, an unaligned address or a write to LAST returns PSLVERR
//   and has no side effects.
//
// Parameters:
//   BASE_ADDR  byte address of register 0x00
//   CNT_W      counter width (1..32)
//   WAIT_RST   reset value of CFG.WAIT
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high
//   apb_psel_i     APB select
//   apb_penable_i  APB enable (access phase)
//   apb_paddr_i    byte address
//   apb_pwrite_i   1 = write, 0 = read
//   apb_pwdata_i   write data
//   apb_pready_o   transfer completes in the cycle it is high
//   apb_prdata_o   read data, 0 unless pready is high
//   apb_pslverr_o  error response, 0 unless pready is high
//
// Build option:
//   APB_EVT_RDCLR_EN  when defined, a successful read of CNT_A/B/C clears that
//                     counter on the committing edge; otherwise reads are
//                     non-destructive.
// -----------------------------------------------------------------------------
module apb_event_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16,
  parameter logic [3:0]  WAIT_RST  = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apb_psel_i,
  input  logic        apb_penable_i,
  input  logic [31:0] apb_paddr_i,
  input  logic        apb_pwrite_i,
  input  logic [31:0] apb_pwdata_i,
  output logic        apb_pready_o,
  output logic [31:0] apb_prdata_o,
  output logic        apb_pslverr_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_t;

  state_t state;
  state_t state_nxt;

  // Transfer captured at the setup phase; decode never looks at the live bus.
  logic [31:0] lat_addr;
  logic        lat_wr;
  logic [31:0] lat_wdata;
  logic [3:0]  wcnt;

  // Architectural registers.
  logic [CNT_W-1:0] cnt [3];
  logic [31:0]      last_data;
  logic [3:0]       wait_cfg;

  logic        setup;
  logic        access;
  logic        commit;
  logic [31:0] off;
  logic        err;
  logic        is_cnt;
  logic        is_cfg;
  logic [1:0]  idx;
  logic [31:0] rdata_mux;

  assign setup  = apb_psel_i & ~apb_penable_i;
  assign access = apb_psel_i &  apb_penable_i;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (setup) state_nxt = (wait_cfg == 4'd0) ? S_READY : S_WAIT;
      end
      S_WAIT: begin
        if (!apb_psel_i)       state_nxt = S_IDLE;
        else if (wcnt == 4'd1) state_nxt = S_READY;
      end
      // READY always lasts one cycle: commit, abort or a malformed access phase
      // all return to IDLE; only a proper access phase commits.
      S_READY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register only)
  // ---------------------------------------------------------------------------
  always_comb begin
    apb_pready_o  = (state == S_READY);
    commit        = apb_pready_o & access;
    apb_pslverr_o = apb_pready_o & err;
    apb_prdata_o  = (apb_pready_o && !err && !lat_wr) ? rdata_mux : 32'h0;
  end

  // ---------------------------------------------------------------------------
  // Setup-phase capture and wait-state counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr  <= 32'h0;
      lat_wr    <= 1'b0;
      lat_wdata <= 32'h0;
      wcnt      <= 4'd0;
    end else if (state == S_IDLE && setup) begin
      lat_addr  <= apb_paddr_i;
      lat_wr    <= apb_pwrite_i;
      lat_wdata <= apb_pwdata_i;
      wcnt      <= wait_cfg;
    end else if (state == S_WAIT) begin
      wcnt      <= wcnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode on the latched transfer
  // ---------------------------------------------------------------------------
  always_comb begin
    // Addresses below BASE_ADDR wrap to a huge offset and land in the error range.
    off    = lat_addr - BASE_ADDR;
    err    = (off > 32'h10) || (lat_addr[1:0] != 2'b00) || (lat_wr && off == 32'hC);
    idx    = off[3:2];
    is_cnt = !err && (off < 32'hC);
    is_cfg = !err && (off == 32'h10);

    rdata_mux = 32'h0;
    if (is_cnt)                rdata_mux = 32'(cnt[idx]);
    else if (off == 32'hC)     rdata_mux = last_data;
    else if (is_cfg)           rdata_mux = {28'h0, wait_cfg};
  end

  // ---------------------------------------------------------------------------
  // Register side effects, all on the committing edge of a successful transfer
  // ---------------------------------------------------------------------------
  // NOTE: the counter array is reset like ordinary flops; these are software-
  // visible registers that must read 0 after reset, not a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      last_data <= 32'h0;
      wait_cfg  <= WAIT_RST;
    end else if (commit && !err) begin
      if (lat_wr) begin
        if (is_cnt) begin
          if (cnt[idx] != '1) cnt[idx] <= cnt[idx] + CNT_W'(1);
          last_data <= lat_wdata;
        end else if (is_cfg) begin
          // New WAIT only affects transfers whose setup follows this edge.
          wait_cfg <= lat_wdata[3:0];
          if (lat_wdata[31]) begin
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
          end
        end
      end
`ifdef APB_EVT_RDCLR_EN
      else if (is_cnt) begin
        cnt[idx] <= '0;
      end
`else
`endif
    end
  end

endmodule
